// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian byte stream into 32-bit words and writes imem.
// Define IMEM_LOADER_CHECKSUM_EN to consume and check a trailing XOR byte.
module imem_loader #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4096,
  parameter int CNT_W  = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_words,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              chk_err
);

  localparam int SW = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE, RECV, WRITE, CHK, DONE
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  widx;
  logic [1:0]        bcnt;
  logic [23:0]       part;
  logic [SW-1:0]     span;
  logic              range_bad;
  logic              hs;
  logic              last_word;

  // Range check is one bit wider than the address so it cannot wrap.
  assign span      = SW'(base_addr) + SW'(num_words);
  assign range_bad = span > SW'(DEPTH);
  assign hs        = s_valid && s_ready;
  assign last_word = (widx + CNT_W'(1)) == num_q;

  assign s_ready = (state == RECV) || (state == CHK);
  assign wr_en   = (state == WRITE);
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (range_bad || num_words == '0)
            state_n = DONE;
          else
            state_n = RECV;
        end
      end
      RECV: begin
        if (hs && bcnt == 2'd3) state_n = WRITE;
      end
      WRITE: begin
        if (!last_word) state_n = RECV;
        else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_n = CHK;
`else
          state_n = DONE;
`endif
        end
      end
      CHK: begin
        if (hs) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q  <= '0;
      num_q   <= '0;
      widx    <= '0;
      bcnt    <= '0;
      part    <= '0;
      err     <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      if (state == IDLE && start) begin
        base_q <= base_addr;
        num_q  <= num_words;
        widx   <= '0;
        bcnt   <= '0;
        err    <= range_bad;
      end
      if (state == RECV && hs) begin
        bcnt <= bcnt + 2'd1;
        part <= {part[15:0], s_data};
        if (bcnt == 2'd3) begin
          wr_addr <= base_q + ADDR_W'(widx);
          wr_data <= {part, s_data};
        end
      end
      if (state == WRITE) widx <= widx + CNT_W'(1);
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xsum;
  logic       chk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xsum  <= '0;
      chk_q <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        xsum  <= '0;
        chk_q <= 1'b0;
      end
      if (state == RECV && hs) xsum <= xsum ^ s_data;
      if (state == CHK && hs)  chk_q <= (s_data != xsum);
    end
  end

  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader.
// Reference model derives writes and status from the load request and bytes.
module tb_imem_loader;

  localparam int AW    = 16;
  localparam int DEPTH = 4096;
  localparam int CW    = 13;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] num_words = '0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = '0;
  logic          s_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          busy;
  logic          done;
  logic          err;
  logic          chk_err;

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_W(AW),
    .DEPTH(DEPTH),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .base_addr(base_addr),
    .num_words(num_words),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .busy(busy),
    .done(done),
    .err(err),
    .chk_err(chk_err)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t         exp_wr[$];
  logic [1:0]  exp_done[$];
  logic [31:0] fixed[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  bit          gaps = 1'b1;
  wr_t         mon_w;
  logic [1:0]  mon_d;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event seen, none expected", nm);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (exp_wr.size() == 0) fail("unexpected_wr");
        else begin
          mon_w = exp_wr.pop_front();
          check("wr_addr", 64'(wr_addr), 64'(mon_w.a));
          check("wr_data", 64'(wr_data), 64'(mon_w.d));
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_done.size() == 0) fail("unexpected_done");
        else begin
          mon_d = exp_done.pop_front();
          check("done_err", 64'(err), 64'(mon_d[1]));
          check("done_chk_err", 64'(chk_err), 64'(mon_d[0]));
        end
      end
    end
  end

  task automatic send_byte(logic [7:0] b);
    int  t;
    bit  hs;
    t = 0;
    while (1) begin
      start = 1'b0;
      if (gaps && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          start     = 1'b1;
          base_addr = AW'($urandom());
          num_words = CW'($urandom());
        end
        @(negedge clk);
      end else begin
        s_valid = 1'b1;
        s_data  = b;
        hs      = s_ready;
        @(negedge clk);
        if (hs) break;
      end
      t++;
      if (t > 200) begin
        check("byte_accept_timeout", 64'(t), 64'(0));
        break;
      end
    end
    start   = 1'b0;
    s_valid = 1'b0;
  endtask

  task automatic load(int base, int n, bit use_fixed, bit bad_chk);
    int          d0;
    int          t;
    logic [31:0] w;
    logic [7:0]  x;
    wr_t         e;
    bit          bad_range;
    bit          imm;
    x         = '0;
    bad_range = (base + n > DEPTH);
    imm       = bad_range || (n == 0);
    exp_done.push_back({bad_range, CHK_EN && !imm && bad_chk});
    d0        = done_cnt;
    start     = 1'b1;
    base_addr = AW'(base);
    num_words = CW'(n);
    s_valid   = imm;
    s_data    = 8'hA5;
    @(negedge clk);
    start = 1'b0;
    if (imm) begin
      check("imm_done", 64'(done), 64'(1));
      for (int k = 0; k < 3; k++) begin
        check("imm_no_ready", 64'(s_ready), 64'(0));
        @(negedge clk);
      end
      s_valid = 1'b0;
    end else begin
      check("busy_after_start", 64'(busy), 64'(1));
      check("ready_in_recv", 64'(s_ready), 64'(1));
      for (int i = 0; i < n; i++) begin
        w = use_fixed ? fixed[i] : $urandom();
        for (int j = 0; j < 4; j++) begin
          x = x ^ w[31-8*j -: 8];
          if (j == 3) begin
            e.a = AW'(base + i);
            e.d = w;
            exp_wr.push_back(e);
          end
          send_byte(w[31-8*j -: 8]);
        end
      end
      if (CHK_EN) send_byte(bad_chk ? (x ^ 8'h0F) : x);
    end
    t = 0;
    while (done_cnt == d0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check("done_once", 64'(done_cnt - d0), 64'(1));
    check("idle_not_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_wr_en", 64'(wr_en), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    check("rst_chk_err", 64'(chk_err), 64'(0));
    check("rst_wr_addr", 64'(wr_addr), 64'(0));
    check("rst_wr_data", 64'(wr_data), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    fixed = '{32'h00221820};
    gaps  = 1'b0;
    load(0, 1, 1'b1, 1'b0);
    gaps  = 1'b1;
    load(10, 3, 1'b0, 1'b0);
    load(4095, 2, 1'b0, 1'b0);
    check("err_sticky", 64'(err), 64'(1));
    load(5, 0, 1'b0, 1'b0);
    check("err_cleared", 64'(err), 64'(0));

    start     = 1'b1;
    base_addr = 16'd20;
    num_words = 13'd1;
    @(negedge clk);
    start = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    rst_n = 1'b0;
    #1;
    exp_done.delete();
    check("mid_rst_s_ready", 64'(s_ready), 64'(0));
    check("mid_rst_wr_en", 64'(wr_en), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_done", 64'(done), 64'(0));
    check("mid_rst_wr_addr", 64'(wr_addr), 64'(0));
    check("mid_rst_wr_data", 64'(wr_data), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    load(20, 1, 1'b0, 1'b0);

    if (CHK_EN) begin
      fixed = '{32'h01020408};
      load(0, 1, 1'b1, 1'b0);
      check("chk_ok", 64'(chk_err), 64'(0));
      load(0, 1, 1'b1, 1'b1);
      check("chk_bad_sticky", 64'(chk_err), 64'(1));
      load(1, 1, 1'b0, 1'b0);
      check("chk_cleared", 64'(chk_err), 64'(0));
    end

    load(DEPTH - 3, 3, 1'b0, 1'b0);
    load(DEPTH - 2, 3, 1'b0, 1'b0);
    load(16'hFFFF, 1, 1'b0, 1'b0);
    load(0, DEPTH + 1, 1'b0, 1'b0);
    repeat (8) begin
      load(int'($urandom_range(0, 4100)), int'($urandom_range(0, 6)),
           1'b0, 1'($urandom_range(0, 1)));
    end

    check("wr_queue_empty", 64'(exp_wr.size()), 64'(0));
    check("done_queue_empty", 64'(exp_done.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
